// File: rtl/load_unit_pkg.sv
// Shared definitions for the load execution unit: opcodes, error codes, FSM states.
package load_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_OPCODE   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    REQ_WAIT = 2'd2,
    WB       = 2'd3
  } state_t;

  function automatic logic is_load_op(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Data-memory read port shared with the store path: one request, one response.
interface load_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_rvalid, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_rvalid, output mem_rdata);
endinterface

// File: rtl/load_unit_sign_extend.sv
// Sign-extends the 16-bit I-type immediate to 32 bits.
module load_unit_sign_extend (
  input  logic        [15:0] imm,
  output logic signed [31:0] imm_ext
);
  assign imm_ext = {{16{imm[15]}}, imm};
endmodule

// File: rtl/load_unit.sv
// Multi-cycle load unit: address generation, single memory read, byte/half/word
// extraction and register-file writeback.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instruction,
  input  logic [31:0] Read_data1,
  load_unit_if.master mem,
  output logic        RegWrite,
  output logic [4:0]  Write_register,
  output logic [31:0] Write_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  error
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t             state, state_nxt;
  logic        [5:0]  op_q;
  logic        [4:0]  rt_q;
  logic        [15:0] imm_q;
  logic        [31:0] base_q;
  logic signed [31:0] imm_ext;
  logic        [31:0] ea;
  logic        [15:0] cnt_q;
  logic        [31:0] addr_q;
  logic        [1:0]  err_nxt;
  logic               take_data;

  // The rs field was already consumed by register read upstream.
  logic unused_rs_field;
  assign unused_rs_field = ^instruction[25:21];

  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] off);
    return ((op == OP_LW) && (off != 2'b00)) ||
           (((op == OP_LH) || (op == OP_LHU)) && off[0]);
  endfunction

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] extract_load(input logic [5:0] op, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic signed [7:0]  byte_v;
    logic signed [15:0] half_v;
    byte_v = rdata[{off, 3'b000} +: 8];
    half_v = rdata[{off[1], 4'b0000} +: 16];
    case (op)
      OP_LB:   return {{24{byte_v[7]}}, byte_v};
      OP_LBU:  return {24'h0, byte_v};
      OP_LH:   return {{16{half_v[15]}}, half_v};
      OP_LHU:  return {16'h0, half_v};
      default: return rdata;
    endcase
  endfunction

  load_unit_sign_extend u_sext (
    .imm     (imm_q),
    .imm_ext (imm_ext)
  );

  // Address add wraps modulo 2^32.
  assign ea = base_q + imm_ext;

  // Capture the operands of an accepted start; held stable for the whole operation.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_q   <= instruction[31:26];
      rt_q   <= instruction[20:16];
      imm_q  <= instruction[15:0];
      base_q <= Read_data1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and the error code to report on entry to WB.
  always_comb begin
    state_nxt = state;
    err_nxt   = ERR_OK;
    take_data = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CHECK;
      CHECK: begin
        if (!is_load_op(op_q)) begin
          err_nxt   = ERR_OPCODE;
          state_nxt = WB;
        end else if (misaligned(op_q, ea[1:0])) begin
          err_nxt   = ERR_MISALIGN;
          state_nxt = WB;
        end else begin
          state_nxt = REQ_WAIT;
        end
      end
      REQ_WAIT: begin
        // Data arriving on the expiry cycle still counts as a successful load.
        if (mem.mem_rvalid) begin
          take_data = 1'b1;
          state_nxt = WB;
        end else if (cnt_q == TIMEOUT_CNT) begin
          err_nxt   = ERR_TIMEOUT;
          state_nxt = WB;
        end
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request address, wait counter and writeback result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q         <= 32'h0;
      cnt_q          <= 16'h0;
      error          <= ERR_OK;
      Write_register <= 5'd0;
      Write_data     <= 32'h0;
    end else begin
      if (state == CHECK) begin
        addr_q <= {ea[31:2], 2'b00};
        cnt_q  <= 16'h0;
      end else if (state == REQ_WAIT) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (state_nxt == WB) begin
        error          <= err_nxt;
        Write_register <= rt_q;
        if (take_data) Write_data <= extract_load(op_q, ea[1:0], mem.mem_rdata);
      end
    end
  end

  assign mem.mem_req  = (state == REQ_WAIT);
  assign mem.mem_addr = addr_q;
  assign busy         = (state != IDLE);
  assign done         = (state == WB);
  assign RegWrite     = (state == WB) && (error == ERR_OK) && (Write_register != 5'd0);

endmodule
